// File: rtl/alu_operand_stage.sv
// alu_operand_stage: collects two upstream words into an operand pair
// (A, then B with a select bit) and holds the pair for a downstream 2:1 mux
// until it is accepted. When a pair is accepted in the same cycle as a new
// word arrives, the new word becomes the next A, so pairs stream back to back.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_data/in_sel    upstream word and select bit (select taken with B only)
//   in_valid/in_ready upstream handshake
//   flush             discards any partial or held pair
//   out_a/out_b       held operands (mux i0 / i1)
//   out_sel           held select (mux j)
//   out_valid/out_ready downstream handshake
//   pair_cnt          count of completed output transfers, wraps at 256
module alu_operand_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pair_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   cap_a;
  logic   cap_b;
  logic   in_xfer;
  logic   out_xfer;

  // out_valid decodes the state register directly, so it carries no input path.
  assign out_valid = (state == FULL);

  // Only combinational paths: reset/flush gating and out_ready pass-through in FULL.
  assign in_ready = rst_n & ~flush & ((state != FULL) | out_ready);

  assign in_xfer  = in_valid & in_ready;
  // A flush cancels any same-cycle output transfer.
  assign out_xfer = out_valid & out_ready & ~flush;

  // Next state and capture enables.
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          cap_a     = 1'b1;
          state_nxt = HALF;
        end
      end
      HALF: begin
        if (in_xfer) begin
          cap_b     = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        // in_xfer implies out_xfer here, since in_ready follows out_ready.
        if (out_xfer) begin
          if (in_xfer) begin
            cap_a     = 1'b1;
            state_nxt = HALF;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // State, operand and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_a    <= '0;
      out_b    <= '0;
      out_sel  <= 1'b0;
      pair_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (cap_a) begin
        out_a <= in_data;
      end
      if (cap_b) begin
        out_b   <= in_data;
        out_sel <= in_sel;
      end
      if (out_xfer) begin
        pair_cnt <= 8'(pair_cnt + 8'd1);
      end
    end
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, WIDTH, operand word from upstream.
REQ-005 The block SHALL have port in_sel, input, 1, select bit, sampled only with the second word of a pair.
REQ-006 The block SHALL have port in_valid, input, 1, upstream word valid.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a word.
REQ-008 The block SHALL have port flush, input, 1, discard any partial or held pair.
REQ-009 The block SHALL have port out_a, output, WIDTH, held operand A, which drives the 16-bit 2:1 mux i0 input.
REQ-010 The block SHALL have port out_b, output, WIDTH, held operand B, which drives the mux i1 input.
REQ-011 The block SHALL have port out_sel, output, 1, held select, which drives the mux j input.
REQ-012 The block SHALL have port out_valid, output, 1, a complete pair is held.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accepts the pair.
REQ-014 The block SHALL have port pair_cnt, output, 8, count of completed output transfers.

Function
REQ-015 An input transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 The FSM SHALL have states EMPTY, HALF and FULL.
REQ-017 In EMPTY, in_ready SHALL be 1 and out_valid SHALL be 0; on an input transfer, in_data SHALL be captured into out_a and the FSM SHALL go to HALF.
REQ-018 In HALF, in_ready SHALL be 1 and out_valid SHALL be 0; on an input transfer, in_data SHALL be captured into out_b, in_sel into out_sel, and the FSM SHALL go to FULL.
REQ-019 In FULL, out_valid SHALL be 1 and in_ready SHALL equal out_ready combinationally, with no other combinational input-to-output paths.
REQ-020 In FULL, an output transfer without an input transfer SHALL move the FSM to EMPTY.
REQ-021 In FULL, a simultaneous output and input transfer SHALL capture in_data into out_a and move the FSM to HALF, so that words stream with no bubble.
REQ-022 While out_valid=1 and out_ready=0, out_a, out_b and out_sel SHALL hold stable.
REQ-023 Latency SHALL be one cycle: out_valid rises on the cycle after the second word is accepted.
REQ-024 Minimum pair throughput SHALL be one pair per two cycles.
REQ-025 out_a SHALL be unchanged by a B capture; out_b and out_sel SHALL be unchanged by an A capture.
REQ-026 A stale out_b and out_sel while in HALF SHALL be permitted, since out_valid=0.
REQ-027 pair_cnt SHALL increment by 1 on each output transfer and wrap from 255 to 0.
REQ-028 flush=1 SHALL force the FSM to EMPTY at the next edge, ignoring any same-cycle input or output transfer.
REQ-029 While flush=1, in_ready SHALL be 0 and pair_cnt SHALL NOT increment.
REQ-030 flush SHALL leave the data registers and pair_cnt unchanged.
REQ-031 in_sel SHALL be ignored on A captures.
REQ-032 in_data SHALL be ignored when no input transfer occurs.

Reset
REQ-033 With rst_n=0 at a rising edge, the FSM SHALL go to EMPTY, out_a, out_b and pair_cnt SHALL become 0, and out_sel and out_valid SHALL become 0.
REQ-034 While rst_n=0, in_ready SHALL be 0.
REQ-035 Reset SHALL have priority over flush and all handshakes.
REQ-036 Reset asserted in HALF or FULL SHALL discard the pair with no output transfer.
REQ-037 The first edge with rst_n=1 SHALL behave as EMPTY.

Verification
REQ-038 The bench SHALL cover the basic pair: words 0x1234, then 0xABCD with in_sel=1, out_ready=1 -> next cycle out_a=0x1234, out_b=0xABCD, out_sel=1, out_valid=1; following edge out_valid=0, pair_cnt=1.
REQ-039 The bench SHALL cover backpressure: FULL with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 throughout, outputs stable, pair_cnt unchanged.
REQ-040 The bench SHALL cover streaming: in_valid=1 and out_ready=1 continuously with words 1,2,3,4,... -> pairs (1,2),(3,4),... each out_valid for exactly one cycle, one pair per two cycles.
REQ-041 The bench SHALL cover the simultaneous case: FULL with (5,6) while out_ready=1 and in_data=7 accepted -> next state HALF, out_a=7, pair_cnt incremented once.
REQ-042 The bench SHALL cover flush and reset mid-pair: flush=1 in HALF -> EMPTY, next accepted word becomes A; rst_n=0 in FULL -> out_valid=0, out_a=0, pair_cnt=0 next edge.
REQ-043 The bench SHALL cover wrap: 256 output transfers -> pair_cnt=0.
